// File: rtl/nco_clkgen_if.sv
// nco_clkgen_if: configuration request channel of the NCO clock-enable generator.
//   cfg_valid : requester holds a configuration request
//   cfg_ready : generator can accept a request (only while locked)
//   cfg_chan  : target channel
//   cfg_inc   : new phase increment (0 disables the channel)
//   cfg_phase : accumulator start value for the target channel
// master = requester side, slave = generator side.
interface nco_clkgen_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACC_W    = 32
) ();
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_chan, cfg_inc, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_inc, cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/nco_clkgen.sv
// nco_clkgen: multi-channel runtime-reprogrammable clock-enable generator.
// Each channel is a phase accumulator clocked by refclk producing a one-cycle
// tick per wrap and a near-50% square wave (accumulator MSB). A settle state
// machine re-aligns every channel after reset or any accepted reconfiguration
// and reports locked once LOCK_CYCLES edges have passed.
//   refclk : single clock, rising edge
//   rst    : asynchronous active-high reset
//   cfg    : configuration request channel (slave side)
//   tick   : per-channel one-cycle pulse on accumulator wrap
//   outclk : per-channel registered accumulator MSB
//   locked : all channels aligned and settled
module nco_clkgen #(
  parameter int unsigned               CHANNELS    = 2,
  parameter int unsigned               ACC_W       = 32,
  parameter int unsigned               LOCK_CYCLES = 16,
  parameter logic [CHANNELS*ACC_W-1:0] INC_INIT    = {32'h051EB852, 32'h80000000}
) (
  input  logic                refclk,
  input  logic                rst,
  nco_clkgen_if.slave         cfg,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] outclk,
  output logic                locked
);

  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                locked_q;
  logic                ready_q;
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] outclk_q;

  logic [ACC_W-1:0]    inc_q   [CHANNELS];
  logic [ACC_W-1:0]    phase_q [CHANNELS];
  logic [ACC_W-1:0]    acc_q   [CHANNELS];

  logic [CH_W-1:0]     req_chan_q;
  logic [ACC_W-1:0]    req_inc_q;
  logic [ACC_W-1:0]    req_phase_q;

  logic [ACC_W-1:0]    req_inc_d;
  logic [ACC_W:0]      sum_d   [CHANNELS];
  logic                req_in_range;

  // Clamp requested increment to refclk/2 and form {carry, acc} sums.
  always_comb begin
    req_inc_d = (cfg.cfg_inc > INC_MAX) ? INC_MAX : cfg.cfg_inc;
    for (int i = 0; i < CHANNELS; i++) begin
      sum_d[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // Out-of-range channel numbers still relock but touch no channel register.
  assign req_in_range = 32'(req_chan_q) < CHANNELS;

  // Settle/lock FSM plus per-channel accumulators.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= SETTLE;
      cnt_q       <= CNT_W'(LOCK_CYCLES - 1);
      locked_q    <= 1'b0;
      ready_q     <= 1'b0;
      tick_q      <= '0;
      outclk_q    <= '0;
      req_chan_q  <= '0;
      req_inc_q   <= '0;
      req_phase_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        inc_q[i]   <= INC_INIT[i*ACC_W +: ACC_W];
        phase_q[i] <= '0;
        acc_q[i]   <= '0;
      end
    end else begin
      unique case (state_q)
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LOCKED: begin
          if (cfg.cfg_valid && ready_q) begin
            state_q     <= APPLY;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
            req_chan_q  <= cfg.cfg_chan;
            req_inc_q   <= req_inc_d;
            req_phase_q <= cfg.cfg_phase;
          end
        end
        APPLY: begin
          state_q <= SETTLE;
          cnt_q   <= CNT_W'(LOCK_CYCLES - 1);
        end
        default: begin
          state_q  <= SETTLE;
          cnt_q    <= CNT_W'(LOCK_CYCLES - 1);
          locked_q <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase

      for (int i = 0; i < CHANNELS; i++) begin
        if (state_q == APPLY) begin
          // Realign: every accumulator restarts from its (possibly new) phase.
          tick_q[i]   <= 1'b0;
          outclk_q[i] <= 1'b0;
          if (req_in_range && (32'(req_chan_q) == 32'(i))) begin
            inc_q[i]   <= req_inc_q;
            phase_q[i] <= req_phase_q;
            acc_q[i]   <= req_phase_q;
          end else begin
            acc_q[i] <= phase_q[i];
          end
        end else if (inc_q[i] != '0) begin
          acc_q[i]    <= sum_d[i][ACC_W-1:0];
          tick_q[i]   <= sum_d[i][ACC_W];
          outclk_q[i] <= sum_d[i][ACC_W-1];
        end else begin
          // Disabled channel: accumulator frozen, outputs quiet.
          tick_q[i]   <= 1'b0;
          outclk_q[i] <= 1'b0;
        end
      end
    end
  end

  assign tick          = tick_q;
  assign outclk        = outclk_q;
  assign locked        = locked_q;
  assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_nco_clkgen.sv
// tb_nco_clkgen: scoreboard bench for nco_clkgen. A closed-form model
// (acc = start + k*inc) predicts tick/outclk/locked for every edge; the
// prediction is queued at the edge and compared on the following falling edge.
module tb_nco_clkgen;
  localparam int unsigned CHANNELS    = 3;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam logic [CHANNELS*ACC_W-1:0] INC_INIT =
    {32'h20000000, 32'h051EB852, 32'h80000000};

  logic                refclk = 1'b0;
  logic                rst    = 1'b1;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] outclk;
  logic                locked;

  nco_clkgen_if #(.CHANNELS(CHANNELS), .ACC_W(ACC_W)) cfg_if ();

  nco_clkgen #(
    .CHANNELS    (CHANNELS),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .INC_INIT    (INC_INIT)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg    (cfg_if),
    .tick   (tick),
    .outclk (outclk),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int                  ed;
    logic [CHANNELS-1:0] tk;
    logic [CHANNELS-1:0] oc;
    logic                chk_oc;
    logic                lk;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state
  int          e;
  int          s_edge;
  int          m_origin;
  logic        pend;
  int          r_chan;
  logic [31:0] r_inc, r_phase;
  logic [31:0] m_inc   [CHANNELS];
  logic [31:0] m_phase [CHANNELS];
  logic [31:0] m_start [CHANNELS];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_inc[i]   = INC_INIT[i*ACC_W +: ACC_W];
      m_phase[i] = '0;
      m_start[i] = '0;
    end
    m_origin = 0;
    s_edge   = 0;
    pend     = 1'b0;
    e        = 0;
  endtask

  function automatic void chan_exp(input int i, output logic t, output logic o);
    longint unsigned k, s, p;
    if (m_inc[i] == 32'd0) begin
      t = 1'b0;
      o = 1'b0;
    end else begin
      k = 64'(e - m_origin);
      s = 64'(m_start[i]) + k * 64'(m_inc[i]);
      p = s - 64'(m_inc[i]);
      t = (s >> ACC_W) != (p >> ACC_W);
      o = s[ACC_W-1];
    end
  endfunction

  // One rising edge: advance the model and queue the prediction.
  task automatic step(output logic accepted);
    exp_t x;
    logic t, o, prev_lk;
    accepted = 1'b0;
    @(posedge refclk);
    e++;
    prev_lk  = (e - 1) >= (s_edge + int'(LOCK_CYCLES));
    x.chk_oc = 1'b1;
    if (pend) begin
      pend = 1'b0;
      if (r_chan < int'(CHANNELS)) begin
        m_inc[r_chan]   = r_inc;
        m_phase[r_chan] = r_phase;
      end
      for (int i = 0; i < CHANNELS; i++) m_start[i] = m_phase[i];
      m_origin = e;
      x.chk_oc = 1'b0;
    end else if (cfg_if.cfg_valid && prev_lk) begin
      pend     = 1'b1;
      accepted = 1'b1;
      s_edge   = e + 1;
      r_chan   = int'(cfg_if.cfg_chan);
      r_inc    = (cfg_if.cfg_inc > 32'h80000000) ? 32'h80000000 : cfg_if.cfg_inc;
      r_phase  = cfg_if.cfg_phase;
    end
    x.ed = e;
    x.lk = e >= (s_edge + int'(LOCK_CYCLES));
    for (int i = 0; i < CHANNELS; i++) begin
      if (!x.chk_oc) begin
        t = 1'b0;
        o = 1'b0;
      end else begin
        chan_exp(i, t, o);
      end
      x.tk[i] = t;
      x.oc[i] = o;
    end
    sb_q.push_back(x);
    #1;
  endtask

  task automatic run(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  // Hold a request until the model says it was taken.
  task automatic send(input int chan, input logic [31:0] inc, input logic [31:0] ph);
    logic a;
    int   n;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 2'(chan);
    cfg_if.cfg_inc   = inc;
    cfg_if.cfg_phase = ph;
    a = 1'b0;
    n = 0;
    while (!a && n < 64) begin
      step(a);
      n++;
    end
    if (!a) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout chan=%0d waited=%0d limit=64", chan, n);
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    sb_q.delete();
    cfg_if.cfg_valid = 1'b0;
    repeat (3) @(negedge refclk);
    check_eq("rst_tick",   64'(tick),             64'd0);
    check_eq("rst_outclk", 64'(outclk),           64'd0);
    check_eq("rst_locked", 64'(locked),           64'd0);
    check_eq("rst_ready",  64'(cfg_if.cfg_ready), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard consumer
  always @(negedge refclk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check_eq($sformatf("tick@%0d", x.ed),   64'(tick),             64'(x.tk));
      if (x.chk_oc)
        check_eq($sformatf("outclk@%0d", x.ed), 64'(outclk),         64'(x.oc));
      check_eq($sformatf("locked@%0d", x.ed), 64'(locked),           64'(x.lk));
      check_eq($sformatf("ready@%0d", x.ed),  64'(cfg_if.cfg_ready), 64'(x.lk));
    end
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_inc   = '0;
    cfg_if.cfg_phase = '0;
    model_reset();

    reset_seq();
    run(200);

    send(1, 32'h40000000, 32'hC0000000);
    run(40);

    send(0, 32'hF0000000, 32'h00000000);
    run(30);

    send(1, 32'h00000000, 32'h00000000);
    run(60);
    send(1, 32'h051EB852, 32'h00000000);
    run(120);

    send(2, 32'h08000000, 32'h00000000);
    send(3, 32'h12345678, 32'h9ABCDEF0);
    run(60);

    // Reset while in APPLY: outputs must clear without waiting for a clock.
    send(0, 32'h10000000, 32'h00000000);
    #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check_eq("async_tick",   64'(tick),             64'd0);
    check_eq("async_outclk", 64'(outclk),           64'd0);
    check_eq("async_locked", 64'(locked),           64'd0);
    check_eq("async_ready",  64'(cfg_if.cfg_ready), 64'd0);
    reset_seq();
    run(200);

    @(negedge refclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
